char_buf_ctrl: RTL and testbench
================================

Name: char_buf_ctrl

Overview:
- Owns the 32x32 character-code buffer that the board text overlay reads through its char_xy address.
- Arbitrates single-cell writes between two requesters, round-robin with valid/ready handshakes:
  - port A: game logic revealing cell numbers/flags.
  - port B: status overlay writing counters and messages.
- Sequences a full-buffer clear to a blank code after reset and on a new-game command.
- Read data is registered: 1-cycle latency from rd_addr to rd_code, feeding the font ROM lookup.

Parameters:
- ADDR_W, 10, buffer address width; address = {col[4:0], row[4:0]}, matching the char_xy layout.
- CODE_W, 7, character code width.
- BLANK_CODE, 7'h20, code written during clear.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  ADDR_W  read address from the overlay draw path (char_xy).
- rd_code  out  CODE_W  registered read data.
- clear_start  in  1  one-cycle pulse; requests a full-buffer clear.
- busy  out  1  high while clearing.
- clear_done  out  1  one-cycle pulse when a clear completes.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A accept.
- a_addr  in  ADDR_W  port A target cell.
- a_code  in  CODE_W  port A code.
- b_valid, b_ready, b_addr, b_code: same as port A, for port B.

Behaviour:
- Reset values: rd_code=0, busy=0, clear_done=0, a_ready=0, b_ready=0, state=INIT, clear counter=0, rr pointer=A.
- States: INIT, CLEAR, IDLE.
  - INIT: lasts 1 cycle, then unconditional move to CLEAR. Buffer contents after power-up are undefined; the first clear defines them.
  - CLEAR:
    - busy=1.
    - Each cycle writes BLANK_CODE at counter, then counter++.
    - When counter==2^ADDR_W-1: that write completes, next state=IDLE, clear_done=1 for exactly that next cycle, counter wraps to 0.
    - Duration is exactly 1024 write cycles.
  - IDLE:
    - busy=0.
    - clear_start=1 -> CLEAR with counter=0. No ready is asserted that cycle; clear has priority over writes.
- clear_start during CLEAR restarts the counter at 0; clear_done fires only once, at the end of the restarted sweep.
- Handshake:
  - Requester holds valid, addr and code stable until it sees valid&ready in the same cycle.
  - ready is combinational from state, valids and pointer; it never depends on ready.
  - a_ready/b_ready are 0 in INIT and CLEAR, and 0 in IDLE when clear_start=1.
- Arbitration in IDLE:
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> the port selected by the rr pointer gets ready.
  - After each accepted transfer, the pointer moves to the other port.
  - At most one ready per cycle.
- Write timing:
  - The accepted transfer writes the RAM on that same clock edge.
  - Back-to-back accepts every cycle are allowed (1 write/cycle throughput).
- Read port is fully independent of writes and clears.
  - rd_code(t+1) = mem[rd_addr(t)].
  - Same-address read during write returns old data (read-first).
  - During CLEAR, a read returns either blank or old data; the draw path tolerates this.
- rst mid-clear or mid-handshake: every register returns to its reset value and the sequence restarts from INIT; a pending transfer is not written.

Decomposition:
- char_buf_pkg:
  - ADDR_W, CODE_W, BLANK_CODE.
  - typedef enum logic [1:0] {INIT, CLEAR, IDLE} cbc_state_t.
  - typedef struct packed {addr, code} char_wr_t.
- Sub-module char_buf_ram:
  - Simple dual-port RAM, 2^ADDR_W x CODE_W.
  - One synchronous write port, one registered read port, read-first.
  - No reset on the array; rd_code register is reset.
- Top level: FSM, clear counter, round-robin arbiter, write mux (clear data vs A vs B).

Test Plan:
1. Reset, then wait. Required: busy rises at cycle 2 after rst release and stays high 1024 cycles, then clear_done pulses once. Reading addresses 0, 517 and 1023 returns 7'h20.
2. In IDLE, port A only: a_addr={5'd3,5'd7}=10'h067, a_code=7'h31. Required: a_ready=1 that cycle; rd_addr=10'h067 next cycle gives rd_code=7'h31 one cycle later.
3. A and B valid continuously, pointer at A; A writes 0x31 to addr 1, then 0x32 to addr 2; B writes 0x41 to addr 3, then 0x42 to addr 4. Required grant order A, B, A, B over 4 consecutive cycles, and all four codes read back.
4. clear_start asserted in the same cycle as a_valid. Required: a_ready=0, busy=1 next cycle. A is accepted only after clear_done, and its code survives the clear.
5. clear_start pulsed again at clear counter=500. Required: counter restarts at 0, total busy=1 for 501+1024 cycles, and exactly one clear_done.
6. rst asserted for 1 cycle while B valid, with b_ready about to be granted. Required: no write occurs, outputs return to reset values, and a fresh 1024-cycle clear follows.

Source files
------------

// File: rtl/char_buf_pkg.sv
// Shared types and sizing for the board text-overlay character buffer.
// Address layout is {col[4:0], row[4:0]}, matching char_xy.
package char_buf_pkg;
    localparam int ADDR_W = 10;
    localparam int CODE_W = 7;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CODE_W-1:0] BLANK_CODE = 7'h20;

    typedef enum logic [1:0] {INIT, CLEAR, IDLE} cbc_state_t;

    typedef enum logic {PORT_A, PORT_B} rr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CODE_W-1:0] code;
    } char_wr_t;
endpackage

// File: rtl/char_buf_if.sv
// Single-cell write request channel with a valid/ready handshake.
interface char_buf_if;
    import char_buf_pkg::*;

    logic     valid;
    logic     ready;
    char_wr_t wr;

    modport master (output valid, output wr, input ready);
    modport slave (input valid, input wr, output ready);
endinterface

// File: rtl/char_buf_ram.sv
// 2^ADDR_W x CODE_W simple dual-port RAM, read-first, registered read.
module char_buf_ram
    import char_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  char_wr_t          wr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [CODE_W-1:0] rd_code_o
);
    logic [CODE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_i.addr] <= wr_i.code;
        end
    end

    // Only the output register is reset; the array stays reset-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_code_o <= '0;
        end else begin
            rd_code_o <= mem_q[rd_addr_i];
        end
    end
endmodule

// File: rtl/char_buf_ctrl.sv
// Character buffer controller: clear sequencer, two-port round-robin
// write arbiter and the registered read path for the overlay.
module char_buf_ctrl
    import char_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CODE_W-1:0] rd_code,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    char_buf_if.slave         a,
    char_buf_if.slave         b
);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    cbc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    rr_t               rr_q, rr_d;
    logic              done_q, done_d;
    logic              a_gnt, b_gnt;
    logic              we;
    char_wr_t          wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rr_q    <= PORT_A;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        done_d  = 1'b0;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        we      = 1'b0;
        wr      = '{addr: cnt_q, code: BLANK_CODE};
        unique case (state_q)
            INIT: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: begin
                we = 1'b1;
                if (clear_start) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    a_gnt = a.valid & (~b.valid | (rr_q == PORT_A));
                    b_gnt = b.valid & (~a.valid | (rr_q == PORT_B));
                    if (a_gnt) begin
                        we   = 1'b1;
                        wr   = a.wr;
                        rr_d = PORT_B;
                    end else if (b_gnt) begin
                        we   = 1'b1;
                        wr   = b.wr;
                        rr_d = PORT_A;
                    end
                end
            end
            default: state_d = INIT;
        endcase
        // A transfer offered during reset must never land in the RAM.
        if (rst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
            we    = 1'b0;
        end
    end

    assign a.ready    = a_gnt;
    assign b.ready    = b_gnt;
    assign busy       = (state_q == CLEAR);
    assign clear_done = done_q;

    char_buf_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .wr_i      (wr),
        .rd_addr_i (rd_addr),
        .rd_code_o (rd_code)
    );
endmodule

// File: tb/tb_char_buf_ctrl.sv
// Self-checking bench for char_buf_ctrl: arbitration table,
// read scoreboard and hand-written clear/reset sequences.
module tb_char_buf_ctrl;
    import char_buf_pkg::*;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr;
    logic [CODE_W-1:0] rd_code;
    logic              clear_start;
    logic              busy;
    logic              clear_done;

    char_buf_if a_if ();
    char_buf_if b_if ();

    char_buf_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_code     (rd_code),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .a           (a_if),
        .b           (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [CODE_W-1:0] model [DEPTH];
    logic [ADDR_W-1:0] rdq [$];
    logic [CODE_W-1:0] expq [$];

    typedef struct {
        logic              av;
        logic              bv;
        logic [ADDR_W-1:0] aa;
        logic [CODE_W-1:0] ac;
        logic [ADDR_W-1:0] ba;
        logic [CODE_W-1:0] bc;
        logic              ea;
        logic              eb;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic blank_model();
        foreach (model[i]) model[i] = BLANK_CODE;
    endtask

    // Issue queued reads back to back; each result is checked one cycle later.
    task automatic rd_burst();
        int n = rdq.size();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                chk($sformatf("rd_code@%0h", rdq[i-1]), int'(rd_code),
                    int'(expq.pop_front()));
            end
            if (i < n) begin
                rd_addr = rdq[i];
                expq.push_back(model[rdq[i]]);
            end
        end
        rdq.delete();
    endtask

    // Follow a clear to its end; optionally restart it at counter value restart_at.
    task automatic run_clear(input int restart_at, output int nb,
                             output int nd, output logic ar);
        bit hit;
        hit = 0;
        nb  = 0;
        nd  = 0;
        ar  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            clear_start = (!hit && restart_at >= 0 && nb == restart_at);
            if (clear_start) hit = 1;
            #1;
            if (clear_done) nd++;
            if (busy) begin
                nb++;
            end else if (nb > 0) begin
                ar = a_if.ready;
                break;
            end
        end
        @(negedge clk);
        clear_start = 1'b0;
        a_if.valid  = 1'b0;
        b_if.valid  = 1'b0;
        #1;
        if (clear_done) nd++;
    endtask

    initial begin
        int   nb;
        int   nd;
        logic ar;

        tbl[0] = '{0, 1, 10'h000, 7'h00, 10'h100, 7'h55, 0, 1};
        tbl[1] = '{1, 1, 10'h001, 7'h31, 10'h003, 7'h41, 1, 0};
        tbl[2] = '{1, 1, 10'h002, 7'h32, 10'h003, 7'h41, 0, 1};
        tbl[3] = '{1, 1, 10'h002, 7'h32, 10'h004, 7'h42, 1, 0};
        tbl[4] = '{1, 1, 10'h005, 7'h33, 10'h004, 7'h42, 0, 1};
        tbl[5] = '{1, 0, 10'h005, 7'h33, 10'h000, 7'h00, 1, 0};
        tbl[6] = '{0, 0, 10'h000, 7'h00, 10'h000, 7'h00, 0, 0};
        tbl[7] = '{1, 1, 10'h007, 7'h35, 10'h008, 7'h43, 0, 1};
        tbl[8] = '{1, 1, 10'h007, 7'h35, 10'h009, 7'h44, 1, 0};

        rst         = 1'b1;
        rd_addr     = '0;
        clear_start = 1'b0;
        a_if.valid  = 1'b0;
        a_if.wr     = '0;
        b_if.valid  = 1'b0;
        b_if.wr     = '0;

        // Reset state and power-up clear
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_code", int'(rd_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clear_done", int'(clear_done), 0);
        chk("rst_a_ready", int'(a_if.ready), 0);
        chk("rst_b_ready", int'(b_if.ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_busy", int'(busy), 0);
        run_clear(-1, nb, nd, ar);
        chk("clear1_busy_cycles", nb, 1024);
        chk("clear1_done_pulses", nd, 1);
        blank_model();
        rdq = '{10'd0, 10'd517, 10'd1023};
        rd_burst();

        // Port A alone, with a same-address read-first check
        @(negedge clk);
        a_if.valid = 1'b1;
        a_if.wr    = '{10'h067, 7'h31};
        rd_addr    = 10'h067;
        expq.push_back(model[10'h067]);
        #1;
        chk("t2_a_ready", int'(a_if.ready), 1);
        chk("t2_b_ready", int'(b_if.ready), 0);
        model[10'h067] = 7'h31;
        @(negedge clk);
        a_if.valid = 1'b0;
        #1;
        chk("t2_read_first", int'(rd_code), int'(expq.pop_front()));
        rdq = '{10'h067};
        rd_burst();

        // Round-robin arbitration table
        foreach (tbl[i]) begin
            @(negedge clk);
            a_if.valid = tbl[i].av;
            a_if.wr    = '{tbl[i].aa, tbl[i].ac};
            b_if.valid = tbl[i].bv;
            b_if.wr    = '{tbl[i].ba, tbl[i].bc};
            #1;
            chk($sformatf("a_ready[%0d]", i), int'(a_if.ready), int'(tbl[i].ea));
            chk($sformatf("b_ready[%0d]", i), int'(b_if.ready), int'(tbl[i].eb));
            if (tbl[i].ea) model[tbl[i].aa] = tbl[i].ac;
            if (tbl[i].eb) model[tbl[i].ba] = tbl[i].bc;
        end
        @(negedge clk);
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        rdq = '{10'h100, 10'h001, 10'h002, 10'h003,
                10'h004, 10'h005, 10'h007, 10'h008, 10'h009};
        rd_burst();

        // clear_start beats a simultaneous A request
        @(negedge clk);
        a_if.valid  = 1'b1;
        a_if.wr     = '{10'h200, 7'h7a};
        clear_start = 1'b1;
        #1;
        chk("t4_a_ready_blocked", int'(a_if.ready), 0);
        run_clear(-1, nb, nd, ar);
        chk("t4_busy_cycles", nb, 1024);
        chk("t4_done_pulses", nd, 1);
        chk("t4_a_ready_after", int'(ar), 1);
        blank_model();
        model[10'h200] = 7'h7a;
        rdq = '{10'h200, 10'h067};
        rd_burst();

        // Restarted clear at counter 500
        @(negedge clk);
        clear_start = 1'b1;
        run_clear(500, nb, nd, ar);
        chk("t5_busy_cycles", nb, 1525);
        chk("t5_done_pulses", nd, 1);
        blank_model();
        rdq = '{10'h200, 10'h1f4};
        rd_burst();

        // Reset while B is about to be granted
        @(negedge clk);
        b_if.valid = 1'b1;
        b_if.wr    = '{10'h3ff, 7'h66};
        rst        = 1'b1;
        #1;
        chk("t6_b_ready_in_rst", int'(b_if.ready), 0);
        @(negedge clk);
        rst        = 1'b0;
        b_if.valid = 1'b0;
        rd_addr    = 10'h3ff;
        #1;
        chk("t6_rd_code", int'(rd_code), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_clear_done", int'(clear_done), 0);
        @(negedge clk);
        #1;
        chk("t6_no_write", int'(rd_code), int'(BLANK_CODE));
        chk("t6_busy_rise", int'(busy), 1);
        run_clear(-1, nb, nd, ar);
        chk("t6_busy_cycles", nb, 1023);
        chk("t6_done_pulses", nd, 1);
        @(negedge clk);
        a_if.valid = 1'b1;
        a_if.wr    = '{10'h010, 7'h11};
        b_if.valid = 1'b1;
        b_if.wr    = '{10'h011, 7'h22};
        #1;
        chk("t6_rr_a_ready", int'(a_if.ready), 1);
        chk("t6_rr_b_ready", int'(b_if.ready), 0);
        model[10'h010] = 7'h11;
        @(negedge clk);
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        rdq = '{10'h010, 10'h011};
        rd_burst();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
